// File: rtl/ctrl_pipe.sv
// ctrl_pipe: RV32I control path (decode, ID/EX, MEM_LAT MEM stages, MEM/WB).
// Optional: define CTRL_ILLEGAL_EN to flag unknown opcodes in EX.
module ctrl_pipe #(
  parameter int RA_W    = 5,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid_i,
  input  logic [6:0]      id_opcode_i,
  input  logic [RA_W-1:0] id_rs1_i,
  input  logic [RA_W-1:0] id_rs2_i,
  input  logic [RA_W-1:0] id_rd_i,
  input  logic            ex_flush_i,
  input  logic            hold_i,
  output logic            stall_o,
  output logic            ex_valid_o,
  output logic [1:0]      ex_alu_op_o,
  output logic [1:0]      ex_alu_src1_o,
  output logic [1:0]      ex_alu_src2_o,
  output logic            ex_branch_o,
  output logic            ex_jump_o,
  output logic            ex_jalr_o,
  output logic [RA_W-1:0] ex_rd_o,
  output logic            mem_valid_o,
  output logic            mem_rd_en_o,
  output logic            mem_wr_en_o,
  output logic [RA_W-1:0] mem_rd_o,
  output logic            wb_valid_o,
  output logic            wb_reg_wr_o,
  output logic [1:0]      wb_sel_o,
  output logic [RA_W-1:0] wb_rd_o,
  output logic            ex_illegal_o
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef struct packed {
    logic            valid;
    logic            reg_wr;
    logic            mem_rd;
    logic            mem_wr;
    logic [1:0]      alu_op;
    logic [1:0]      src1;
    logic [1:0]      src2;
    logic [1:0]      wb_sel;
    logic            branch;
    logic            jump;
    logic            jalr;
    logic            illegal;
    logic [RA_W-1:0] rd;
  } ex_t;

  typedef struct packed {
    logic            valid;
    logic            reg_wr;
    logic            mem_rd;
    logic            mem_wr;
    logic [1:0]      wb_sel;
    logic [RA_W-1:0] rd;
  } mem_t;

  typedef struct packed {
    logic            valid;
    logic            reg_wr;
    logic [1:0]      wb_sel;
    logic [RA_W-1:0] rd;
  } wb_t;

  ex_t                dec;
  ex_t                ex_d;
  ex_t                ex_q;
  mem_t [MEM_LAT-1:0] mem_d;
  mem_t [MEM_LAT-1:0] mem_q;
  wb_t                wb_d;
  wb_t                wb_q;
  logic               use_rs1;
  logic               use_rs2;
  logic               haz;

  // Decode the ID opcode into a full bundle; invalid ID gives a bubble
  always_comb begin
    dec     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (id_opcode_i)
      OP_R: begin
        dec.reg_wr = 1'b1;
        dec.alu_op = 2'b10;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
      end
      OP_I: begin
        dec.reg_wr = 1'b1;
        dec.alu_op = 2'b10;
        dec.src2   = 2'b01;
        use_rs1    = 1'b1;
      end
      OP_LOAD: begin
        dec.reg_wr = 1'b1;
        dec.mem_rd = 1'b1;
        dec.src2   = 2'b01;
        dec.wb_sel = 2'b01;
        use_rs1    = 1'b1;
      end
      OP_STORE: begin
        dec.mem_wr = 1'b1;
        dec.src2   = 2'b01;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
      end
      OP_BR: begin
        dec.alu_op = 2'b01;
        dec.branch = 1'b1;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
      end
      OP_LUI: begin
        dec.reg_wr = 1'b1;
        dec.src1   = 2'b10;
        dec.src2   = 2'b01;
      end
      OP_AUIPC: begin
        dec.reg_wr = 1'b1;
        dec.src1   = 2'b01;
        dec.src2   = 2'b01;
      end
      OP_JAL: begin
        dec.reg_wr = 1'b1;
        dec.src1   = 2'b01;
        dec.src2   = 2'b10;
        dec.wb_sel = 2'b10;
        dec.jump   = 1'b1;
      end
      OP_JALR: begin
        dec.reg_wr = 1'b1;
        dec.src2   = 2'b01;
        dec.wb_sel = 2'b10;
        dec.jump   = 1'b1;
        dec.jalr   = 1'b1;
        use_rs1    = 1'b1;
      end
      default: begin
`ifdef CTRL_ILLEGAL_EN
        dec.illegal = 1'b1;
`else
        dec.illegal = 1'b0;
`endif
      end
    endcase
    dec.valid = 1'b1;
    dec.rd    = id_rd_i;
    if (!id_valid_i) begin
      dec = '0;
    end
  end

  // Load-use check against loads that have not reached the last MEM stage
  always_comb begin
    haz = 1'b0;
    if (ex_q.valid && ex_q.mem_rd && (ex_q.rd != '0)) begin
      if ((use_rs1 && (id_rs1_i == ex_q.rd)) ||
          (use_rs2 && (id_rs2_i == ex_q.rd))) begin
        haz = 1'b1;
      end
    end
    for (int i = 0; i < MEM_LAT - 1; i++) begin
      if (mem_q[i].valid && mem_q[i].mem_rd && (mem_q[i].rd != '0)) begin
        if ((use_rs1 && (id_rs1_i == mem_q[i].rd)) ||
            (use_rs2 && (id_rs2_i == mem_q[i].rd))) begin
          haz = 1'b1;
        end
      end
    end
  end

  assign stall_o = id_valid_i & haz & ~rst;

  // Advance the pipe unless frozen; flush or stall inserts an EX bubble
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!hold_i) begin
      if (ex_flush_i || stall_o) begin
        ex_d = '0;
      end else begin
        ex_d = dec;
      end
      mem_d[0].valid  = ex_q.valid;
      mem_d[0].reg_wr = ex_q.reg_wr;
      mem_d[0].mem_rd = ex_q.mem_rd;
      mem_d[0].mem_wr = ex_q.mem_wr;
      mem_d[0].wb_sel = ex_q.wb_sel;
      mem_d[0].rd     = ex_q.rd;
      for (int i = 1; i < MEM_LAT; i++) begin
        mem_d[i] = mem_q[i-1];
      end
      wb_d.valid  = mem_q[MEM_LAT-1].valid;
      wb_d.reg_wr = mem_q[MEM_LAT-1].reg_wr;
      wb_d.wb_sel = mem_q[MEM_LAT-1].wb_sel;
      wb_d.rd     = mem_q[MEM_LAT-1].rd;
    end
  end

  // Stage registers; reset drops everything in flight at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign ex_valid_o    = ex_q.valid;
  assign ex_alu_op_o   = ex_q.alu_op;
  assign ex_alu_src1_o = ex_q.src1;
  assign ex_alu_src2_o = ex_q.src2;
  assign ex_branch_o   = ex_q.branch;
  assign ex_jump_o     = ex_q.jump;
  assign ex_jalr_o     = ex_q.jalr;
  assign ex_rd_o       = ex_q.rd;
  assign ex_illegal_o  = ex_q.illegal;

  assign mem_valid_o = mem_q[MEM_LAT-1].valid;
  assign mem_rd_en_o = mem_q[MEM_LAT-1].mem_rd;
  assign mem_wr_en_o = mem_q[MEM_LAT-1].mem_wr;
  assign mem_rd_o    = mem_q[MEM_LAT-1].rd;

  assign wb_valid_o  = wb_q.valid;
  assign wb_reg_wr_o = wb_q.reg_wr;
  assign wb_sel_o    = wb_q.wb_sel;
  assign wb_rd_o     = wb_q.rd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed checks of ctrl_pipe at MEM_LAT=1 and MEM_LAT=3.
// Both instances share stimulus; expectations are hand-derived per instance.
module tb_ctrl_pipe;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [6:0] id_op;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       flush, hold;

  logic       s1, ev1, br1, jp1, jr1, mv1, mre1, mwe1, wv1, wrw1, ill1;
  logic [1:0] aop1, sa1, sb1, wsel1;
  logic [4:0] erd1, mrd1, wrd1;
  logic       s3, ev3, br3, jp3, jr3, mv3, mre3, mwe3, wv3, wrw3, ill3;
  logic [1:0] aop3, sa3, sb3, wsel3;
  logic [4:0] erd3, mrd3, wrd3;

  logic [33:0] all1, all3;
  logic [8:0]  ctl1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ctrl_pipe #(.RA_W(5), .MEM_LAT(1)) u1 (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_opcode_i(id_op),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
    .ex_flush_i(flush), .hold_i(hold), .stall_o(s1),
    .ex_valid_o(ev1), .ex_alu_op_o(aop1), .ex_alu_src1_o(sa1),
    .ex_alu_src2_o(sb1), .ex_branch_o(br1), .ex_jump_o(jp1),
    .ex_jalr_o(jr1), .ex_rd_o(erd1), .mem_valid_o(mv1),
    .mem_rd_en_o(mre1), .mem_wr_en_o(mwe1), .mem_rd_o(mrd1),
    .wb_valid_o(wv1), .wb_reg_wr_o(wrw1), .wb_sel_o(wsel1),
    .wb_rd_o(wrd1), .ex_illegal_o(ill1)
  );

  ctrl_pipe #(.RA_W(5), .MEM_LAT(3)) u3 (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_opcode_i(id_op),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
    .ex_flush_i(flush), .hold_i(hold), .stall_o(s3),
    .ex_valid_o(ev3), .ex_alu_op_o(aop3), .ex_alu_src1_o(sa3),
    .ex_alu_src2_o(sb3), .ex_branch_o(br3), .ex_jump_o(jp3),
    .ex_jalr_o(jr3), .ex_rd_o(erd3), .mem_valid_o(mv3),
    .mem_rd_en_o(mre3), .mem_wr_en_o(mwe3), .mem_rd_o(mrd3),
    .wb_valid_o(wv3), .wb_reg_wr_o(wrw3), .wb_sel_o(wsel3),
    .wb_rd_o(wrd3), .ex_illegal_o(ill3)
  );

  assign all1 = {s1, ev1, aop1, sa1, sb1, br1, jp1, jr1, erd1,
                 mv1, mre1, mwe1, mrd1, wv1, wrw1, wsel1, wrd1, ill1};
  assign all3 = {s3, ev3, aop3, sa3, sb3, br3, jp3, jr3, erd3,
                 mv3, mre3, mwe3, mrd3, wv3, wrw3, wsel3, wrd3, ill3};
  assign ctl1 = {aop1, sa1, sb1, br1, jp1, jr1};

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idi(input logic v, input logic [6:0] op,
                     input logic [4:0] a, input logic [4:0] b,
                     input logic [4:0] d);
    id_valid = v;
    id_op    = op;
    id_rs1   = a;
    id_rs2   = b;
    id_rd    = d;
  endtask

  task automatic drain(input int n);
    idi(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    hold  = 1'b0;
    idi(1'b1, OP_R, 5'd1, 5'd2, 5'd3);
    #3;
    chk("reset_u1", all1, 0);
    chk("reset_u3", all3, 0);
    cyc();
    cyc();
    rst = 1'b0;

    // three in flight, then reset between edges
    idi(1'b1, OP_R, 5'd1, 5'd2, 5'd1);
    cyc();
    idi(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd2);
    cyc();
    idi(1'b1, OP_I, 5'd1, 5'd0, 5'd3);
    cyc();
    chk("inflight_wb_rd", wrd1, 5'd1);
    rst = 1'b1;
    #1;
    chk("midrst_u1", all1, 0);
    chk("midrst_u3", all3, 0);
    idi(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("postrst1_u1", all1, 0);
    cyc();
    chk("postrst2_u1", all1, 0);
    chk("postrst2_u3", all3, 0);

    // R-type latency
    idi(1'b1, OP_R, 5'd1, 5'd2, 5'd3);
    cyc();
    chk("r_ex_ctl", ctl1, 9'b10_00_00_000);
    chk("r_ex_vrd", {ev1, erd1}, {1'b1, 5'd3});
    idi(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    cyc();
    chk("r_mem", {mv1, mre1, mwe1, mrd1}, {3'b100, 5'd3});
    cyc();
    chk("r_wb", {wv1, wrw1, wsel1, wrd1}, {4'b1100, 5'd3});
    cyc();
    chk("r_mem_u3", {mv3, mrd3}, {1'b1, 5'd3});
    chk("r_wb_drained", wv1, 1'b0);
    cyc();
    chk("r_wb_u3", {wv3, wrw3, wsel3, wrd3}, {4'b1100, 5'd3});
    drain(2);

    // load-use, both latencies
    idi(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd5);
    cyc();
    chk("ld_ex_ctl", ctl1, 9'b00_00_01_000);
    idi(1'b1, OP_R, 5'd5, 5'd6, 5'd7);
    #1;
    chk("lu_stall0_u1", s1, 1'b1);
    chk("lu_stall0_u3", s3, 1'b1);
    cyc();
    chk("lu_stall1_u1", s1, 1'b0);
    chk("lu_bubble_u1", ev1, 1'b0);
    chk("lu_mem_u1", {mre1, mrd1}, {1'b1, 5'd5});
    chk("lu_stall1_u3", s3, 1'b1);
    cyc();
    chk("lu_add_ex_u1", {ev1, erd1}, {1'b1, 5'd7});
    chk("lu_wb_u1", {wsel1, wrd1}, {2'b01, 5'd5});
    chk("lu_stall2_u3", s3, 1'b1);
    chk("lu_bubble_u3", ev3, 1'b0);
    cyc();
    chk("lu_stall3_u3", s3, 1'b0);
    chk("lu_mem_u3", {mre3, mrd3}, {1'b1, 5'd5});
    drain(6);

    // load to x0 never stalls
    idi(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd0);
    cyc();
    idi(1'b1, OP_R, 5'd0, 5'd0, 5'd9);
    #1;
    chk("x0_u1", s1, 1'b0);
    chk("x0_u3", s3, 1'b0);
    drain(6);

    // store rs2 dependency stalls, JAL does not
    idi(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd5);
    cyc();
    idi(1'b1, OP_STORE, 5'd1, 5'd5, 5'd0);
    #1;
    chk("st_rs2_u1", s1, 1'b1);
    chk("st_rs2_u3", s3, 1'b1);
    idi(1'b1, OP_JAL, 5'd5, 5'd5, 5'd1);
    #1;
    chk("jal_u1", s1, 1'b0);
    chk("jal_u3", s3, 1'b0);
    cyc();
    chk("jal_ex_ctl", ctl1, 9'b00_01_10_010);
    drain(6);

    // flush together with stall
    idi(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd5);
    cyc();
    idi(1'b1, OP_R, 5'd5, 5'd2, 5'd8);
    flush = 1'b1;
    #1;
    chk("fl_stall", s1, 1'b1);
    cyc();
    flush = 1'b0;
    chk("fl_bubble", ev1, 1'b0);
    cyc();
    chk("fl_redecode", {ev1, erd1, aop1}, {1'b1, 5'd8, 2'b10});
    drain(6);

    // remaining decode rows
    idi(1'b1, OP_BR, 5'd1, 5'd2, 5'd0);
    cyc();
    chk("br_ctl", ctl1, 9'b01_00_00_100);
    idi(1'b1, OP_LUI, 5'd0, 5'd0, 5'd4);
    cyc();
    chk("lui_ctl", ctl1, 9'b00_10_01_000);
    idi(1'b1, OP_AUIPC, 5'd0, 5'd0, 5'd4);
    cyc();
    chk("auipc_ctl", ctl1, 9'b00_01_01_000);
    idi(1'b1, OP_JALR, 5'd1, 5'd0, 5'd4);
    cyc();
    chk("jalr_ctl", ctl1, 9'b00_00_01_011);
    idi(1'b1, OP_STORE, 5'd1, 5'd2, 5'd0);
    cyc();
    chk("st_ctl", ctl1, 9'b00_00_01_000);
    idi(1'b1, OP_BAD, 5'd1, 5'd2, 5'd3);
    cyc();
    chk("bad_ctl", ctl1, 9'd0);
`ifdef CTRL_ILLEGAL_EN
    chk("bad_flag", {ev1, ill1}, 2'b11);
`else
    chk("bad_flag", ill1, 1'b0);
`endif
    chk("st_mem", {mv1, mre1, mwe1}, 3'b101);
    chk("jalr_wb", {wv1, wrw1, wsel1, wrd1}, {4'b1110, 5'd4});
    drain(6);

    // hold freezes every stage
    idi(1'b1, OP_I, 5'd1, 5'd0, 5'd1);
    cyc();
    idi(1'b1, OP_I, 5'd1, 5'd0, 5'd2);
    cyc();
    idi(1'b1, OP_I, 5'd1, 5'd0, 5'd3);
    cyc();
    idi(1'b1, OP_I, 5'd1, 5'd0, 5'd4);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_u1", {erd1, mrd1, wrd1}, {5'd3, 5'd2, 5'd1});
      chk("hold_u3", {erd3, mrd3}, {5'd3, 5'd0});
    end
    hold = 1'b0;
    cyc();
    chk("resume1_u1", {erd1, mrd1, wrd1}, {5'd4, 5'd3, 5'd2});
    chk("resume1_u3", {erd3, mrd3}, {5'd4, 5'd1});
    idi(1'b1, OP_I, 5'd1, 5'd0, 5'd5);
    cyc();
    chk("resume2_u1", {erd1, mrd1, wrd1}, {5'd5, 5'd4, 5'd3});
    drain(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
